mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter S, default 15: data MSB index; data buses are S+1 bits.
REQ-002 Parameter A, default 7: address MSB index; address buses are A+1 bits.
REQ-003 Parameter W, default 2: memory access latency in cycles; legal range W>=1.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 if_req  input  1  fetch-stage read request; held until if_ack.
REQ-007 if_addr  input  A+1  fetch address; stable while if_req high.
REQ-008 if_rdata  output  S+1  registered fetch read data.
REQ-009 if_ack  output  1  one-cycle fetch completion pulse.
REQ-010 mem_req  input  1  MEM-stage request; held until mem_ack.
REQ-011 mem_we  input  1  MEM-stage write enable; 0 means read.
REQ-012 mem_addr  input  A+1  MEM-stage address.
REQ-013 mem_wdata  input  S+1  MEM-stage write data.
REQ-014 mem_rdata  output  S+1  registered MEM-stage read data.
REQ-015 mem_ack  output  1  one-cycle MEM-stage completion pulse.
REQ-016 ram_en, ram_we  output  1 each  registered shared-RAM strobes.
REQ-017 ram_addr  output  A+1, ram_wdata  output  S+1  registered shared-RAM address and data.
REQ-018 ram_rdata  input  S+1  shared-RAM read data; valid in the last BUSY cycle.
REQ-019 stall_if, stall_mem  output  1 each  combinational pipeline-buffer hold signals.

Function
REQ-020 The FSM SHALL have two states: IDLE and BUSY.
REQ-021 A requester SHALL be eligible in IDLE only when its req=1 and its ack=0 in that cycle.
REQ-022 At an IDLE clock edge with one eligible requester, that requester SHALL be granted.
REQ-023 At an IDLE clock edge with both requesters eligible, the requester not granted last SHALL win; last_grant SHALL update on every grant.
REQ-024 On grant, the block SHALL register the requester's address into ram_addr, set ram_en=1, set ram_we to (mem_we if MEM granted, else 0), register mem_wdata into ram_wdata if MEM is granted, load cnt=W, and enter BUSY.
REQ-025 In BUSY, ram_en, ram_we, ram_addr and ram_wdata SHALL remain constant.
REQ-026 In BUSY, cnt SHALL decrement by 1 at each edge where cnt>1.
REQ-027 At the BUSY edge where cnt==1, the block SHALL capture ram_rdata into the granted requester's rdata (reads only), pulse its ack for exactly one cycle, clear ram_en and ram_we, and return to IDLE.
REQ-028 Latency: with a request first sampled at edge k, ack SHALL be high during the cycle following edge k+W.
REQ-029 On a MEM write, mem_rdata SHALL hold its previous value, and mem_ack SHALL still pulse.
REQ-030 if_rdata and mem_rdata SHALL change only on completion of their own read.
REQ-031 stall_if SHALL equal if_req & ~if_ack, and stall_mem SHALL equal mem_req & ~mem_ack.
REQ-032 Request changes during BUSY SHALL NOT affect the access in progress.
REQ-033 A grant SHALL NOT occur in the ack cycle for the acked requester; the other requester MAY be granted at that edge.

Reset
REQ-034 On rst=0, the block SHALL immediately enter IDLE and force ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0, cnt=0 and last_grant=IF.
REQ-035 Reset asserted mid-access SHALL abort the access without ack; after release, a still-held req SHALL be re-arbitrated.

Verification (W=2)
REQ-036 IF read only: if_req=1, if_addr=8'h10, ram_rdata=16'hBEEF -> ram_en high for 2 cycles at addr 8'h10; if_ack pulses 1 cycle; if_rdata=16'hBEEF.
REQ-037 MEM write: mem_we=1, mem_addr=8'h20, mem_wdata=16'h1234 -> ram_we=1 and ram_wdata=16'h1234 for 2 cycles; mem_ack pulses; mem_rdata unchanged.
REQ-038 Contention after reset: both req high -> MEM granted first; IF granted at mem_ack edge; if_ack follows 2 cycles later.
REQ-039 Persistent contention: both held high for 4 accesses -> grant order MEM, IF, MEM, IF; no back-to-back grant to the same requester.
REQ-040 Reset mid-access: rst low during first BUSY cycle -> ram_en=0 immediately; no ack; all outputs 0; req still high after release -> new full 2-cycle access.
REQ-041 Stall: during a MEM access with if_req=1 -> stall_if=1 until if_ack, and stall_mem drops in the mem_ack cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one fixed-latency RAM between the fetch (IF) and
// memory (MEM) pipeline stages; round-robin on contention, one access at a time.
module mem_port_arbiter #(
  parameter int S = 15,
  parameter int A = 7,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [A:0]   if_addr,
  output logic [S:0]   if_rdata,
  output logic         if_ack,
  input  logic         mem_req,
  input  logic         mem_we,
  input  logic [A:0]   mem_addr,
  input  logic [S:0]   mem_wdata,
  output logic [S:0]   mem_rdata,
  output logic         mem_ack,
  output logic         ram_en,
  output logic         ram_we,
  output logic [A:0]   ram_addr,
  output logic [S:0]   ram_wdata,
  input  logic [S:0]   ram_rdata,
  output logic         stall_if,
  output logic         stall_mem
);

  // state | meaning
  // IDLE  | no access in flight; arbitrate eligible requesters
  // BUSY  | RAM access in flight; cnt counts down to completion
  typedef enum logic {IDLE, BUSY} state_t;

  localparam int CW = (W < 2) ? 1 : $clog2(W + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last_mem;
  logic          cur_mem;
  logic          gnt_if, gnt_mem, done;
  logic          elig_if, elig_mem;

  // A requester whose ack is high this cycle is finishing, not asking again.
  assign elig_if  = if_req & ~if_ack;
  assign elig_mem = mem_req & ~mem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_if    = 1'b0;
    gnt_mem   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (elig_if && elig_mem) begin
          gnt_mem = ~last_mem;
          gnt_if  = last_mem;
        end else begin
          gnt_if  = elig_if;
          gnt_mem = elig_mem;
        end
        if (gnt_if || gnt_mem) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == CW'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      cnt       <= '0;
      last_mem  <= 1'b0;
      cur_mem   <= 1'b0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      if (gnt_if || gnt_mem) begin
        ram_addr <= gnt_mem ? mem_addr : if_addr;
        ram_en   <= 1'b1;
        ram_we   <= gnt_mem & mem_we;
        if (gnt_mem) ram_wdata <= mem_wdata;
        cnt      <= CW'(W);
        cur_mem  <= gnt_mem;
        last_mem <= gnt_mem;
      end else if (state == BUSY) begin
        if (done) begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          cnt    <= '0;
          if (cur_mem) begin
            mem_ack <= 1'b1;
            if (!ram_we) mem_rdata <= ram_rdata;
          end else begin
            if_ack   <= 1'b1;
            if_rdata <= ram_rdata;
          end
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: protocol-correct requesters, random
// resets and RAM data, checked against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int S = 15;
  localparam int A = 7;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         if_req = 1'b0;
  logic [A:0]   if_addr = '0;
  logic [S:0]   if_rdata;
  logic         if_ack;
  logic         mem_req = 1'b0;
  logic         mem_we = 1'b0;
  logic [A:0]   mem_addr = '0;
  logic [S:0]   mem_wdata = '0;
  logic [S:0]   mem_rdata;
  logic         mem_ack;
  logic         ram_en, ram_we;
  logic [A:0]   ram_addr;
  logic [S:0]   ram_wdata;
  logic [S:0]   ram_rdata = '0;
  logic         stall_if, stall_mem;

  int n_chk = 0;
  int n_err = 0;

  mem_port_arbiter #(.S(S), .A(A), .W(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  // Reference model: a transaction is granted at some edge number and
  // completes exactly W edges later; no down-counter, just edge arithmetic.
  int         cyc, done_at;
  logic       active, owner_mem, last_mem;
  logic       e_if_ack, e_mem_ack, e_en, e_we;
  logic [A:0] e_addr;
  logic [S:0] e_wdata, e_if_rdata, e_mem_rdata;
  logic       el_if, el_mem, pick_mem;

  assign el_if    = if_req & ~e_if_ack;
  assign el_mem   = mem_req & ~e_mem_ack;
  assign pick_mem = el_mem & (~el_if | ~last_mem);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc <= 0; done_at <= 0; active <= 1'b0; owner_mem <= 1'b0; last_mem <= 1'b0;
      e_if_ack <= 1'b0; e_mem_ack <= 1'b0; e_en <= 1'b0; e_we <= 1'b0;
      e_addr <= '0; e_wdata <= '0; e_if_rdata <= '0; e_mem_rdata <= '0;
    end else begin
      cyc       <= cyc + 1;
      e_if_ack  <= 1'b0;
      e_mem_ack <= 1'b0;
      if (active && cyc == done_at) begin
        active <= 1'b0;
        e_en   <= 1'b0;
        e_we   <= 1'b0;
        if (owner_mem) begin
          e_mem_ack <= 1'b1;
          if (!e_we) e_mem_rdata <= ram_rdata;
        end else begin
          e_if_ack   <= 1'b1;
          e_if_rdata <= ram_rdata;
        end
      end else if (!active && (el_if || el_mem)) begin
        active    <= 1'b1;
        done_at   <= cyc + W;
        owner_mem <= pick_mem;
        last_mem  <= pick_mem;
        e_en      <= 1'b1;
        e_we      <= pick_mem & mem_we;
        e_addr    <= pick_mem ? mem_addr : if_addr;
        if (pick_mem) e_wdata <= mem_wdata;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check("ram_en", 64'(ram_en), 64'(e_en));
    check("ram_we", 64'(ram_we), 64'(e_we));
    check("ram_addr", 64'(ram_addr), 64'(e_addr));
    check("ram_wdata", 64'(ram_wdata), 64'(e_wdata));
    check("if_ack", 64'(if_ack), 64'(e_if_ack));
    check("mem_ack", 64'(mem_ack), 64'(e_mem_ack));
    check("if_rdata", 64'(if_rdata), 64'(e_if_rdata));
    check("mem_rdata", 64'(mem_rdata), 64'(e_mem_rdata));
    check("stall_if", 64'(stall_if), 64'(if_req & ~e_if_ack));
    check("stall_mem", 64'(stall_mem), 64'(mem_req & ~e_mem_ack));
  endtask

  logic if_pend, mem_pend;

  initial begin
    if_pend  = 1'b0;
    mem_pend = 1'b0;
    repeat (2) @(negedge clk);
    check_all();
    // Contention straight out of reset: MEM must win first.
    if_req = 1'b1; if_addr = 8'h10; if_pend = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 8'h20; mem_wdata = 16'h1234; mem_pend = 1'b1;
    ram_rdata = 16'hBEEF;
    rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      check_all();
      if (e_if_ack)  if_pend  = 1'b0;
      if (e_mem_ack) mem_pend = 1'b0;
      if (!if_pend) begin
        if ($urandom_range(0, 2) != 0) begin
          if_req = 1'b1; if_addr = A'($urandom); if_pend = 1'b1;
        end else begin
          if_req = 1'b0;
        end
      end
      if (!mem_pend) begin
        if ($urandom_range(0, 2) != 0) begin
          mem_req = 1'b1; mem_we = 1'($urandom); mem_addr = A'($urandom);
          mem_wdata = S'($urandom); mem_pend = 1'b1;
        end else begin
          mem_req = 1'b0;
        end
      end
      ram_rdata = S'($urandom);
      if (i > 10 && rst && $urandom_range(0, 59) == 0) rst = 1'b0;
      else if (!rst && $urandom_range(0, 1) == 0) rst = 1'b1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
